fetch_ctrl: RTL and testbench

Front-end fetch sequencer that owns the PC and the single instruction-memory read port. It issues imem reads, forwards each returned instruction with its PC to the instruction queue, holds a response in a skid register while the queue is full, and redirects on branch mispredict, discarding any in-flight stale response. It sits between the imem/I-cache port and the instruction queue's push side.

---
 rtl/rv32i_types.sv | 33 +++
 rtl/fetch_ctrl_if.sv | 37 +++
 rtl/fetch_skid.sv | 43 ++++
 rtl/fetch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// ============================================================================
// Module   : rv32i_types (package)
// Purpose  : Shared front-end types: fetch sequencer state encoding and the
//            pc/instruction packet carried from imem to the instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

   typedef enum logic [1:0] {
      ISSUE  = 2'd0,
      WAIT   = 2'd1,
      SQUASH = 2'd2,
      HOLD   = 2'd3
   } fetch_ctrl_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_pkt_t;

   localparam logic [3:0]  RMASK_WORD = 4'hF;
   localparam logic [31:0] PC_STEP    = 32'd4;

   // Sequential PC; 32-bit modulo so the top of the address space wraps to 0.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module   : fetch_ctrl_if
// Purpose  : Bundles the fetch sequencer's imem read port, instruction-queue
//            push side, redirect input and performance counters.
//            master = fetch sequencer, slave = surrounding front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;
   logic        branch_mispredict;
   logic [31:0] redirect_pc;
   logic        queue_full;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic        imem_resp;
   logic [31:0] imem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic [31:0] perf_fetched;
   logic [31:0] perf_squashed;

   modport master (
      input  branch_mispredict, redirect_pc, queue_full, imem_resp, imem_rdata,
      output imem_addr, imem_rmask, fetch_valid, fetch_pc, fetch_inst,
             perf_fetched, perf_squashed
   );

   modport slave (
      output branch_mispredict, redirect_pc, queue_full, imem_resp, imem_rdata,
      input  imem_addr, imem_rmask, fetch_valid, fetch_pc, fetch_inst,
             perf_fetched, perf_squashed
   );
endinterface

`default_nettype wire

// File: rtl/fetch_skid.sv
// ============================================================================
// Module   : fetch_skid
// Purpose  : Single-entry hold register for a fetched pc/instruction packet
//            that arrived while the instruction queue was full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid
   import rv32i_types::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       load,
   input  wire logic       clear,
   input  wire fetch_pkt_t din,
   output fetch_pkt_t      dout,
   output logic            valid
);

   fetch_pkt_t pkt;
   logic       pkt_valid;

   // Capture a packet on load; clear wipes it back to the reset image.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt       <= '0;
         pkt_valid <= 1'b0;
      end else if (clear) begin
         pkt       <= '0;
         pkt_valid <= 1'b0;
      end else if (load) begin
         pkt       <= din;
         pkt_valid <= 1'b1;
      end
   end

   assign dout  = pkt;
   assign valid = pkt_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch sequencer owning the PC and the single imem read port.
//            Issues reads, pushes pc/inst to the instruction queue, parks a
//            response in a skid register while the queue is full, and
//            redirects on mispredict while discarding stale responses.
//            Optional macro FETCH_CTRL_PERF_EN enables the perf counters;
//            without it both counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
   input  wire logic    clk,
   input  wire logic    rst,
   fetch_ctrl_if.master bus
);

   fetch_ctrl_state_t state, state_nx;
   logic [31:0]       pc, pc_nx, pc_inc;
   logic              skid_load, skid_clear, squash_evt;
   fetch_pkt_t        hold_pkt;
   logic              hold_valid;
   logic [3:0]        rmask;
   logic [31:0]       addr;
   logic              push;
   logic [31:0]       push_pc, push_inst;

   assign pc_inc = next_pc(pc);

   fetch_skid u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .din   ('{pc: pc, inst: bus.imem_rdata}),
      .dout  (hold_pkt),
      .valid (hold_valid)
   );

   // State and PC registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ISSUE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
      end
   end

   // Next state / next PC; pc always names the next word to request or the
   // word currently outstanding.
   always_comb begin
      state_nx   = state;
      pc_nx      = pc;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      squash_evt = 1'b0;
      case (state)
         ISSUE: begin
            if (bus.branch_mispredict)  pc_nx    = bus.redirect_pc;
            else if (!bus.queue_full)   state_nx = WAIT;
         end
         WAIT: begin
            if (bus.branch_mispredict && bus.imem_resp) begin
               pc_nx      = bus.redirect_pc;
               state_nx   = ISSUE;
               squash_evt = 1'b1;
            end else if (bus.branch_mispredict) begin
               pc_nx    = bus.redirect_pc;
               state_nx = SQUASH;
            end else if (bus.imem_resp && !bus.queue_full) begin
               pc_nx = pc_inc;
            end else if (bus.imem_resp) begin
               skid_load = 1'b1;
               pc_nx     = pc_inc;
               state_nx  = HOLD;
            end
         end
         SQUASH: begin
            if (bus.branch_mispredict) pc_nx = bus.redirect_pc;
            if (bus.imem_resp) begin
               state_nx   = ISSUE;
               squash_evt = 1'b1;
            end
         end
         HOLD: begin
            if (bus.branch_mispredict) begin
               skid_clear = 1'b1;
               pc_nx      = bus.redirect_pc;
               state_nx   = ISSUE;
               squash_evt = 1'b1;
            end else if (!bus.queue_full) begin
               skid_clear = 1'b1;
               state_nx   = ISSUE;
            end
         end
         default: state_nx = ISSUE;
      endcase
   end

   // Request and push outputs; both are held quiet while reset is asserted.
   always_comb begin
      rmask     = 4'h0;
      addr      = pc;
      push      = 1'b0;
      push_pc   = '0;
      push_inst = '0;
      if (!rst) begin
         case (state)
            ISSUE: begin
               if (!bus.branch_mispredict && !bus.queue_full) rmask = RMASK_WORD;
            end
            WAIT: begin
               if (!bus.branch_mispredict && bus.imem_resp && !bus.queue_full) begin
                  push      = 1'b1;
                  push_pc   = pc;
                  push_inst = bus.imem_rdata;
                  rmask     = RMASK_WORD;
                  addr      = pc_inc;
               end
            end
            HOLD: begin
               if (!bus.branch_mispredict && !bus.queue_full && hold_valid) begin
                  push      = 1'b1;
                  push_pc   = hold_pkt.pc;
                  push_inst = hold_pkt.inst;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_rmask  = rmask;
   assign bus.imem_addr   = addr;
   assign bus.fetch_valid = push;
   assign bus.fetch_pc    = push_pc;
   assign bus.fetch_inst  = push_inst;

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] cnt_fetched, cnt_squashed;

   // Count pushes and discarded responses / dropped hold entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_fetched  <= '0;
         cnt_squashed <= '0;
      end else begin
         if (push)       cnt_fetched  <= cnt_fetched + 32'd1;
         if (squash_evt) cnt_squashed <= cnt_squashed + 32'd1;
      end
   end

   assign bus.perf_fetched  = cnt_fetched;
   assign bus.perf_squashed = cnt_squashed;
`else
   assign bus.perf_fetched  = '0;
   assign bus.perf_squashed = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Scoreboard bench for fetch_ctrl with a latency-programmable
//            imem model and directed redirect / backpressure / reset vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

   localparam logic [31:0] BASE     = 32'h1eceb000;
   localparam logic [31:0] INST_KEY = 32'hDEADBEEF;

   logic clk;
   logic rst;

   fetch_ctrl_if bus();

   fetch_ctrl #(.RESET_PC(BASE)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   int          mem_lat     = 1;
   logic [31:0] exp_req[$];
   logic [31:0] exp_push[$];

   logic        s_req, s_resp;
   logic [31:0] s_addr;
   bit          pending;
   int          cnt;
   logic [31:0] mem_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_evt(input string name, input logic [31:0] act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %h, expected nothing (t=%0t)", name, act, $time);
   endtask

   task automatic perf_check(input string name, input logic [31:0] act, input logic [31:0] exp_en);
`ifdef FETCH_CTRL_PERF_EN
      check(name, act, exp_en);
`else
      check(name, act, 32'h0);
`endif
   endtask

   // Memory model: accepts a request at a clock edge, answers mem_lat cycles
   // later with a one-cycle strobe; data is address XOR a fixed key.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pending        = 1'b0;
         cnt            = 0;
         bus.imem_resp  = 1'b0;
         bus.imem_rdata = 32'h0;
      end else begin
         #1;
         if (s_resp) pending = 1'b0;
         else if (pending && cnt > 1) cnt--;
         if (s_req) begin
            if (pending) fail_evt("two_outstanding", s_addr);
            pending  = 1'b1;
            cnt      = mem_lat;
            mem_addr = s_addr;
         end
         bus.imem_resp  = pending && (cnt == 1);
         bus.imem_rdata = bus.imem_resp ? (mem_addr ^ INST_KEY) : 32'h0;
      end
   end

   // Monitor: compares every request and every push against the scoreboard.
   always @(negedge clk) begin : mon
      logic [31:0] e;
      if (rst) begin
         s_req  = 1'b0;
         s_resp = 1'b0;
      end else begin
         s_req  = (bus.imem_rmask == 4'hF);
         s_addr = bus.imem_addr;
         s_resp = bus.imem_resp;
         if (bus.imem_rmask != 4'h0 && bus.imem_rmask != 4'hF)
            fail_evt("rmask_value", {28'h0, bus.imem_rmask});
         if (s_req) begin
            if (exp_req.size() == 0) fail_evt("unexpected_req", s_addr);
            else check("req_addr", s_addr, exp_req.pop_front());
         end
         if (bus.fetch_valid) begin
            check("push_while_full", {31'h0, bus.queue_full}, 32'h0);
            if (exp_push.size() == 0) fail_evt("unexpected_push", bus.fetch_pc);
            else begin
               e = exp_push.pop_front();
               check("push_pc", bus.fetch_pc, e);
               check("push_inst", bus.fetch_inst, e ^ INST_KEY);
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rmask"}, {28'h0, bus.imem_rmask}, 32'h0);
      check({tag, "_fetch_valid"}, {31'h0, bus.fetch_valid}, 32'h0);
      check({tag, "_fetch_pc"}, bus.fetch_pc, 32'h0);
      check({tag, "_fetch_inst"}, bus.fetch_inst, 32'h0);
      check({tag, "_perf_fetched"}, bus.perf_fetched, 32'h0);
      check({tag, "_perf_squashed"}, bus.perf_squashed, 32'h0);
   endtask

   task automatic idle_outputs(input string tag);
      check({tag, "_fetch_valid"}, {31'h0, bus.fetch_valid}, 32'h0);
      check({tag, "_rmask"}, {28'h0, bus.imem_rmask}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.branch_mispredict = 1'b0;
      bus.redirect_pc       = 32'h0;
      bus.queue_full        = 1'b0;
      rst                   = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");

      // Streaming from reset with a 1-cycle memory, then backpressure at 0x010.
      foreach (exp_req[i]) exp_req.delete();
      for (int i = 0; i <= 5; i++) exp_req.push_back(BASE + 32'(4 * i));
      for (int i = 0; i <= 4; i++) exp_push.push_back(BASE + 32'(4 * i));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("first_req_rmask", {28'h0, bus.imem_rmask}, 32'hF);
      check("first_req_addr", bus.imem_addr, BASE);
      check("first_req_no_push", {31'h0, bus.fetch_valid}, 32'h0);
      @(negedge clk);
      check("stream_push0", {31'h0, bus.fetch_valid}, 32'h1);
      check("stream_addr1", bus.imem_addr, BASE + 32'h4);
      @(negedge clk);
      check("stream_push1", {31'h0, bus.fetch_valid}, 32'h1);
      check("stream_addr2", bus.imem_addr, BASE + 32'h8);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1 bus.queue_full = 1'b1;
      @(negedge clk);
      idle_outputs("full_resp");
      @(negedge clk);
      @(negedge clk);
      idle_outputs("hold_full");
      @(posedge clk); #1 bus.queue_full = 1'b0;
      @(negedge clk);
      check("hold_push_valid", {31'h0, bus.fetch_valid}, 32'h1);
      check("hold_push_pc", bus.fetch_pc, BASE + 32'h10);
      check("hold_push_rmask", {28'h0, bus.imem_rmask}, 32'h0);
      @(negedge clk);
      check("after_hold_addr", bus.imem_addr, BASE + 32'h14);
      mem_lat = 3;

      // 3-cycle memory: one push and one request pulse every third cycle.
      exp_req.push_back(BASE + 32'h18);
      exp_req.push_back(BASE + 32'h1C);
      exp_req.push_back(BASE + 32'h20);
      exp_push.push_back(BASE + 32'h14);
      exp_push.push_back(BASE + 32'h18);
      exp_push.push_back(BASE + 32'h1C);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         check("lat3_push", {31'h0, bus.fetch_valid}, (k % 3 == 0) ? 32'h1 : 32'h0);
         check("lat3_rmask", {28'h0, bus.imem_rmask}, (k % 3 == 0) ? 32'hF : 32'h0);
      end

      // Mispredict in WAIT before the response: stale data must be dropped.
      exp_req.push_back(BASE + 32'h400);
      @(posedge clk); #1;
      bus.branch_mispredict = 1'b1;
      bus.redirect_pc       = BASE + 32'h400;
      @(negedge clk);
      idle_outputs("wait_mispredict");
      @(posedge clk); #1;
      bus.branch_mispredict = 1'b0;
      mem_lat               = 1;
      @(negedge clk);
      @(negedge clk);
      check("stale_no_push", {31'h0, bus.fetch_valid}, 32'h0);
      @(negedge clk);
      check("redirect_rmask", {28'h0, bus.imem_rmask}, 32'hF);
      check("redirect_addr", bus.imem_addr, BASE + 32'h400);
      perf_check("perf_squashed_1", bus.perf_squashed, 32'd1);
      perf_check("perf_fetched_8", bus.perf_fetched, 32'd8);

      // Mispredict coincident with a response.
      exp_push.push_back(BASE + 32'h400);
      exp_req.push_back(BASE + 32'h404);
      exp_req.push_back(BASE + 32'h400);
      @(negedge clk);
      check("redirect_push_pc", bus.fetch_pc, BASE + 32'h400);
      @(posedge clk); #1 bus.branch_mispredict = 1'b1;
      @(negedge clk);
      idle_outputs("mispredict_with_resp");
      @(posedge clk); #1 bus.branch_mispredict = 1'b0;
      @(negedge clk);
      check("coincident_redirect_addr", bus.imem_addr, BASE + 32'h400);

      // Mispredict while a response is parked in HOLD.
      exp_req.push_back(BASE + 32'h400);
      @(posedge clk); #1 bus.queue_full = 1'b1;
      @(negedge clk);
      check("hold_entry_no_push", {31'h0, bus.fetch_valid}, 32'h0);
      @(posedge clk); #1 bus.branch_mispredict = 1'b1;
      @(negedge clk);
      idle_outputs("hold_mispredict");
      @(posedge clk); #1;
      bus.branch_mispredict = 1'b0;
      bus.queue_full        = 1'b0;
      @(negedge clk);
      check("hold_redirect_rmask", {28'h0, bus.imem_rmask}, 32'hF);
      check("hold_redirect_addr", bus.imem_addr, BASE + 32'h400);
      perf_check("perf_squashed_3", bus.perf_squashed, 32'd3);

      // PC wrap at the top of the address space.
      exp_push.push_back(BASE + 32'h400);
      exp_req.push_back(BASE + 32'h404);
      exp_req.push_back(32'hFFFFFFFC);
      exp_req.push_back(32'h00000000);
      exp_req.push_back(32'h00000004);
      exp_push.push_back(32'hFFFFFFFC);
      exp_push.push_back(32'h00000000);
      @(negedge clk);
      @(posedge clk); #1;
      bus.branch_mispredict = 1'b1;
      bus.redirect_pc       = 32'hFFFFFFFC;
      @(negedge clk);
      check("wrap_redirect_no_push", {31'h0, bus.fetch_valid}, 32'h0);
      @(posedge clk); #1 bus.branch_mispredict = 1'b0;
      @(negedge clk);
      check("wrap_req_addr", bus.imem_addr, 32'hFFFFFFFC);
      perf_check("perf_squashed_4", bus.perf_squashed, 32'd4);
      perf_check("perf_fetched_10", bus.perf_fetched, 32'd10);
      @(negedge clk);
      check("wrap_push_pc", bus.fetch_pc, 32'hFFFFFFFC);
      check("wrap_next_addr", bus.imem_addr, 32'h00000000);
      @(negedge clk);
      check("wrap_addr_4", bus.imem_addr, 32'h00000004);
      mem_lat = 3;
      @(negedge clk);
      check("wait_quiet_rmask", {28'h0, bus.imem_rmask}, 32'h0);
      perf_check("perf_fetched_12", bus.perf_fetched, 32'd12);

      // Asynchronous reset while a request is outstanding.
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      exp_req.push_back(BASE);
      exp_req.push_back(BASE + 32'h4);
      exp_push.push_back(BASE);
      mem_lat = 1;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rerun_rmask", {28'h0, bus.imem_rmask}, 32'hF);
      check("rerun_addr", bus.imem_addr, BASE);
      @(negedge clk);
      check("rerun_push_pc", bus.fetch_pc, BASE);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("req_queue_drained", exp_req.size(), 32'h0);
      check("push_queue_drained", exp_push.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
